// File: rtl/cache_miss_handler_pkg.sv
// Shared definitions for the cache refill path: data/address widths and the
// refill state encoding used by the cache and memory controller.
package cache_miss_handler_pkg;

    localparam int WORD_LENGTH  = 32;
    localparam int ADDR_WIDTH   = 15;
    localparam int OFFSET_WIDTH = 2;
    localparam int CNT_WIDTH    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FILL  = 2'd2
    } state_e;

endpackage

// File: rtl/block_buffer.sv
// Four-word line buffer filled one word at a time during a refill; contents
// persist until the next refill overwrites them.
module block_buffer
    import cache_miss_handler_pkg::*;
#(
    parameter int WIDTH = WORD_LENGTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en_i,
    input  logic [OFFSET_WIDTH-1:0] wr_sel_i,
    input  logic [WIDTH-1:0]        wr_data_i,
    output logic [WIDTH-1:0]        word0_o,
    output logic [WIDTH-1:0]        word1_o,
    output logic [WIDTH-1:0]        word2_o,
    output logic [WIDTH-1:0]        word3_o
);

    logic [3:0][WIDTH-1:0] words_q;

    // NOTE: the buffer is cleared on reset so an aborted refill never leaves a stale partial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q <= '0;
        end else if (wr_en_i) begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
            words_q[wr_sel_i] <= wr_data_i;
        end
    end

    assign word0_o = words_q[0];
    assign word1_o = words_q[1];
    assign word2_o = words_q[2];
    assign word3_o = words_q[3];

endmodule

// File: rtl/cache_miss_handler.sv
// Refill engine: on a miss, fetches the enclosing four-word block in order,
// strobes fill_valid for one cycle, stalls the core throughout, counts misses.
module cache_miss_handler #(
    parameter int WORD_LENGTH = cache_miss_handler_pkg::WORD_LENGTH,
    parameter int ADDR_WIDTH  = cache_miss_handler_pkg::ADDR_WIDTH,
    parameter int CNT_WIDTH   = cache_miss_handler_pkg::CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic                  hit_i,
    output logic                  mem_read_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ready_i,
    input  logic [WORD_LENGTH-1:0] mem_rdata_i,
    output logic [WORD_LENGTH-1:0] block_out1_o,
    output logic [WORD_LENGTH-1:0] block_out2_o,
    output logic [WORD_LENGTH-1:0] block_out3_o,
    output logic [WORD_LENGTH-1:0] block_out4_o,
    output logic                  fill_valid_o,
    output logic [ADDR_WIDTH-3:0] fill_addr_o,
    output logic                  stall_o,
    output logic [CNT_WIDTH-1:0]  miss_count_o
);
    import cache_miss_handler_pkg::*;

    localparam int BLK_WIDTH = ADDR_WIDTH - OFFSET_WIDTH;

    state_e                  state_q, state_d;
    logic [OFFSET_WIDTH-1:0] k_q, k_d;
    logic [BLK_WIDTH-1:0]    fill_addr_q, fill_addr_d;
    logic [CNT_WIDTH-1:0]    miss_count_q, miss_count_d;
    logic                    miss;
    logic                    buf_we;

    assign miss = req_i && !hit_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            fill_addr_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            fill_addr_q  <= fill_addr_d;
            miss_count_q <= miss_count_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d      = state_q;
        k_d          = k_q;
        fill_addr_d  = fill_addr_q;
        miss_count_d = miss_count_q;
        mem_read_o   = 1'b0;
        mem_addr_o   = '0;
        fill_valid_o = 1'b0;
        buf_we       = 1'b0;
        stall_o      = 1'b1;

        unique case (state_q)
            IDLE: begin
                stall_o = miss;
                if (miss) begin
                    fill_addr_d = address_i[ADDR_WIDTH-1:OFFSET_WIDTH];
                    k_d         = '0;
                    if (miss_count_q != '1) begin
                        miss_count_d = miss_count_q + CNT_WIDTH'(1);
                    end
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem_read_o = 1'b1;
                mem_addr_o = {fill_addr_q, k_q};
                if (mem_ready_i) begin
                    buf_we = 1'b1;
                    if (k_q == '1) begin
                        state_d = FILL;
                    end else begin
                        k_d = k_q + OFFSET_WIDTH'(1);
                    end
                end
            end
            FILL: begin
                fill_valid_o = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    block_buffer #(
        .WIDTH (WORD_LENGTH)
    ) u_block_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (buf_we),
        .wr_sel_i  (k_q),
        .wr_data_i (mem_rdata_i),
        .word0_o   (block_out1_o),
        .word1_o   (block_out2_o),
        .word2_o   (block_out3_o),
        .word3_o   (block_out4_o)
    );

    assign fill_addr_o  = fill_addr_q;
    assign miss_count_o = miss_count_q;

endmodule

// File: tb/tb_cache_miss_handler.sv
// Scoreboarded bench: a memory responder checks fetch addresses, a fill
// monitor checks each completed block against a word-level refill model.
module tb_cache_miss_handler;

    localparam int WL = 32;
    localparam int AW = 15;
    localparam int CW = 16;

    typedef struct packed {
        logic [AW-3:0]      blk;
        logic [3:0][WL-1:0] w;
        logic [CW-1:0]      cnt;
    } fill_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_i = 1'b0;
    logic          hit_i = 1'b0;
    logic [AW-1:0] address_i = '0;
    logic          mem_ready_i = 1'b0;
    logic [WL-1:0] mem_rdata_i = '0;
    logic          mem_read_o;
    logic [AW-1:0] mem_addr_o;
    logic [WL-1:0] block_out1_o, block_out2_o, block_out3_o, block_out4_o;
    logic          fill_valid_o;
    logic [AW-3:0] fill_addr_o;
    logic          stall_o;
    logic [CW-1:0] miss_count_o;

    cache_miss_handler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .address_i    (address_i),
        .hit_i        (hit_i),
        .mem_read_o   (mem_read_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ready_i  (mem_ready_i),
        .mem_rdata_i  (mem_rdata_i),
        .block_out1_o (block_out1_o),
        .block_out2_o (block_out2_o),
        .block_out3_o (block_out3_o),
        .block_out4_o (block_out4_o),
        .fill_valid_o (fill_valid_o),
        .fill_addr_o  (fill_addr_o),
        .stall_o      (stall_o),
        .miss_count_o (miss_count_o)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          fill_cyc = -1;
    int          wait_mode = 0;
    int          wait_cnt = 0;
    int          wait_tgt = 0;
    int unsigned model_cnt = 0;
    int unsigned mem_seed = 32'h5A5A_1234;
    fill_t       fill_q[$];
    logic [AW-1:0] addr_q[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Main-memory contents as a pure function of the word address.
    function automatic logic [WL-1:0] mem_word(logic [AW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ mem_seed;
    endfunction

    // Reference model of one refill: fetch order, block contents, saturating count.
    function automatic fill_t push_expect(logic [AW-1:0] addr);
        fill_t e;
        logic [AW-1:0] wa;
        e.blk = addr[AW-1:2];
        for (int k = 0; k < 4; k++) begin
            wa = {addr[AW-1:2], 2'(k)};
            addr_q.push_back(wa);
            e.w[k] = mem_word(wa);
        end
        if (model_cnt < (2**CW - 1)) model_cnt++;
        e.cnt = CW'(model_cnt);
        fill_q.push_back(e);
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder: programmable wait states, checks every fetch address.
    initial forever begin
        @(negedge clk);
        if (mem_read_o === 1'b1) begin
            if (wait_cnt < wait_tgt) begin
                mem_ready_i = 1'b0;
                mem_rdata_i = $urandom;
                wait_cnt++;
                if (addr_q.size() > 0) check("mem_addr_hold", mem_addr_o, addr_q[0]);
            end else begin
                mem_ready_i = 1'b1;
                mem_rdata_i = mem_word(mem_addr_o);
                if (addr_q.size() == 0) check("unexpected_fetch", 1, 0);
                else check("mem_addr", mem_addr_o, addr_q.pop_front());
                wait_cnt = 0;
                wait_tgt = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
            end
        end else begin
            mem_ready_i = 1'($urandom_range(0, 1));
            mem_rdata_i = $urandom;
            wait_cnt    = 0;
            wait_tgt    = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
        end
    end

    // Fill monitor: pops the oldest expected block whenever fill_valid appears.
    initial forever begin
        fill_t e;
        @(negedge clk);
        if (rst_n && fill_valid_o === 1'b1) begin
            fill_cyc = cyc;
            if (fill_q.size() == 0) begin
                check("unexpected_fill", 1, 0);
            end else begin
                e = fill_q.pop_front();
                check("fill_addr", fill_addr_o, e.blk);
                check("block_out1", block_out1_o, e.w[0]);
                check("block_out2", block_out2_o, e.w[1]);
                check("block_out3", block_out3_o, e.w[2]);
                check("block_out4", block_out4_o, e.w[3]);
                check("miss_count", miss_count_o, e.cnt);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req_i = 1'b0;
        fill_q.delete();
        addr_q.delete();
        model_cnt = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // One refill from the miss cycle N to the first idle cycle afterwards.
    task automatic run_miss(logic [AW-1:0] addr, int mode, bit garbage, int exp_lat);
        fill_t e;
        int    n;
        bit    seen;
        wait_mode = mode;
        @(negedge clk);
        @(posedge clk);
        #1;
        req_i     = 1'b1;
        hit_i     = 1'b0;
        address_i = addr;
        n         = cyc;
        fill_cyc  = -1;
        e         = push_expect(addr);
        @(negedge clk);
        check("stall_miss_cycle", stall_o, 1);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (garbage) begin
                req_i     = 1'($urandom);
                hit_i     = 1'($urandom);
                address_i = AW'($urandom);
            end else begin
                req_i = 1'b0;
            end
            @(negedge clk);
            check("stall_refill", stall_o, 1);
            if (fill_valid_o === 1'b1) seen = 1;
        end
        if (!seen) begin
            check("fill_timeout", 0, 1);
            do_reset();
            return;
        end
        if (exp_lat >= 0) check("fill_latency", fill_cyc - n, exp_lat);
        @(posedge clk);
        #1;
        req_i = 1'b0;
        hit_i = 1'b0;
        @(negedge clk);
        check("stall_after_fill", stall_o, 0);
        check("mem_read_idle", mem_read_o, 0);
        check("mem_addr_idle", mem_addr_o, 0);
        check("held_word1", block_out1_o, e.w[0]);
        check("held_word4", block_out4_o, e.w[3]);
        check("held_fill_addr", fill_addr_o, e.blk);
    endtask

    initial begin
        fill_t e;
        // Reset values.
        #2;
        check("rst_mem_read", mem_read_o, 0);
        check("rst_fill_valid", fill_valid_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_miss_count", miss_count_o, 0);
        check("rst_fill_addr", fill_addr_o, 0);
        check("rst_block", {block_out1_o, block_out4_o}, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Hits never start a refill.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            req_i = 1'b1;
            hit_i = 1'b1;
            address_i = 15'h0123;
            @(negedge clk);
            check("hit_stall", stall_o, 0);
            check("hit_mem_read", mem_read_o, 0);
            check("hit_miss_count", miss_count_o, 0);
        end
        req_i = 1'b0;

        // Zero-wait refill, then two wait states per word, then inputs churning mid-refill.
        run_miss(15'h1235, 0, 0, 5);
        run_miss(15'h1235, 2, 0, 13);
        mem_seed = 32'hC0DE_F00D;
        run_miss(15'h0F0A, 0, 1, 5);
        run_miss(15'h7FFF, 1, 1, 9);

        // Reset after the second word has been captured.
        wait_mode = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        req_i = 1'b1;
        hit_i = 1'b0;
        address_i = 15'h2A7E;
        e = push_expect(15'h2A7E);
        @(posedge clk);
        #1 req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("partial_word1", block_out1_o, e.w[0]);
        check("partial_word2", block_out2_o, e.w[1]);
        rst_n = 1'b0;
        fill_q.delete();
        addr_q.delete();
        model_cnt = 0;
        #1;
        check("abort_mem_read", mem_read_o, 0);
        check("abort_fill_valid", fill_valid_o, 0);
        check("abort_stall", stall_o, 0);
        check("abort_miss_count", miss_count_o, 0);
        check("abort_fill_addr", fill_addr_o, 0);
        check("abort_block", {block_out1_o, block_out2_o}, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_still_idle", stall_o, 0);
        run_miss(15'h2A7E, 0, 0, 5);

        // Randomized traffic mixing hits, idle cycles and misses.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                mem_seed = $urandom;
                run_miss(AW'($urandom), -1, 1'($urandom), -1);
            end else begin
                @(posedge clk);
                #1;
                req_i = 1'($urandom);
                hit_i = req_i ? 1'b1 : 1'($urandom);
                address_i = AW'($urandom);
                @(negedge clk);
                check("rand_idle_stall", stall_o, 0);
                check("rand_idle_mem_read", mem_read_o, 0);
            end
        end
        req_i = 1'b0;

        // Counter saturation from one below all-ones.
        @(negedge clk);
        force dut.miss_count_q = 16'hFFFE;
        #1 release dut.miss_count_q;
        model_cnt = 32'hFFFE;
        for (int i = 0; i < 3; i++) run_miss(AW'($urandom), 0, 0, 5);
        @(negedge clk);
        check("saturated_count", miss_count_o, 16'hFFFF);
        check("scoreboard_drained", fill_q.size() + addr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
